// File: rtl/ysyx_22041071_dmem_responder_pkg.sv
// Shared constants and helpers for the data-memory responder.
package ysyx_22041071_dmem_responder_pkg;

    // Physical address where word 0 of the array lives.
    localparam logic [63:0] MEM_BASE = 64'h8000_0000;

    // Access size encodings carried on req_size.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Responder FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Response captured at the acceptance edge and held until handshake.
    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    // Byte-enable pattern of an access before shifting to its lane.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Natural alignment check: the low size bits of the address must be zero.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = |off[1:0];
            default: bad = |off;
        endcase
        return bad;
    endfunction

    // Truncate right-aligned load data to its size and extend; doubles pass through.
    function automatic logic [63:0] extend_load(input logic [63:0] raw, input logic [1:0] size,
                                                input logic is_unsigned);
        logic [63:0] v;
        case (size)
            SZ_B:    v = is_unsigned ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            SZ_H:    v = is_unsigned ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            SZ_W:    v = is_unsigned ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: v = raw;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ysyx_22041071_dmem_array.sv
// DEPTH x 64-bit storage: one synchronous byte-masked write port and one
// combinational read port. Contents are deliberately not reset.
module ysyx_22041071_dmem_array #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wmask,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];

    // Write only the enabled byte lanes; unmasked lanes keep their old value.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (wen && wmask[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_22041071_dmem_responder.sv
// Data-memory responder: accepts one load/store at a time from the MEM stage,
// performs it against the local array on the acceptance edge, and presents the
// result after a fixed LATENCY on the response channel.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// 1. req_ready is 1 only in IDLE; resp_valid is 1 only in RESP and the response
// fields stay constant until the edge where resp_ready is seen high. Because
// RESP always returns to IDLE first, a new request is never accepted on the same
// edge a response completes.
module ysyx_22041071_dmem_responder
    import ysyx_22041071_dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] DEPTH64 = 64'(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]    state;
    logic [3:0]    cnt;
    resp_t         resp_q;
    resp_t         resp_next;

    logic          accept;
    logic [63:0]   rel_addr;
    logic [63:0]   idx_full;
    logic [AW-1:0] idx;
    logic [2:0]    byte_off;
    logic [5:0]    bit_off;
    logic          out_of_range;
    logic          err;
    logic [7:0]    wmask;
    logic [63:0]   wdata_lane;
    logic [63:0]   rword;
    logic [63:0]   load_val;

    assign accept   = (state == ST_IDLE) && req_valid;

    // Address decode: word index relative to the base, byte lane within the word.
    // Below-base addresses wrap to a huge index and are caught by the range check.
    assign rel_addr     = req_addr - MEM_BASE;
    assign idx_full     = rel_addr >> 3;
    assign idx          = idx_full[AW-1:0];
    assign byte_off     = req_addr[2:0];
    assign bit_off      = {byte_off, 3'b000};
    assign out_of_range = (req_addr < MEM_BASE) || (idx_full >= DEPTH64);
    assign err          = misaligned(req_size, byte_off) || out_of_range;

    // Store lane steering; alignment guarantees the mask never spills past byte 7.
    assign wmask      = size_mask(req_size) << byte_off;
    assign wdata_lane = req_wdata << bit_off;

    ysyx_22041071_dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .wen   (accept && req_wen && !err),
        .waddr (idx),
        .wmask (wmask),
        .wdata (wdata_lane),
        .raddr (idx),
        .rdata (rword)
    );

    assign load_val = extend_load(rword >> bit_off, req_size, req_unsigned);

    // Response value formed from the request in flight; stores and errors read 0.
    always_comb begin
        resp_next.err   = err;
        resp_next.rdata = (err || req_wen) ? 64'd0 : load_val;
    end

    // FSM, latency counter and captured response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            resp_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        resp_q <= resp_next;
                        cnt    <= CNT_INIT;
                        state  <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = resp_q.rdata;
    assign resp_err   = resp_q.err;
    assign dbg_state  = state;

endmodule

// File: tb/tb_ysyx_22041071_dmem_responder.sv
// Directed bench for the data-memory responder. Three instances cover
// LATENCY = 1, 4 and 3; each has its own memory and stimulus signals.
module tb_ysyx_22041071_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_wen      [3];
    logic [63:0] req_addr     [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [63:0] req_wdata    [3];
    logic        resp_valid   [3];
    logic        resp_ready   [3];
    logic [63:0] resp_rdata   [3];
    logic        resp_err     [3];
    logic [1:0]  dbg_state    [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [63:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    ysyx_22041071_dmem_responder #(.DEPTH(4096), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .dbg_state(dbg_state[0])
    );

    ysyx_22041071_dmem_responder #(.DEPTH(4096), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .dbg_state(dbg_state[1])
    );

    ysyx_22041071_dmem_responder #(.DEPTH(4096), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_wen(req_wen[2]),
        .req_addr(req_addr[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
        .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]), .dbg_state(dbg_state[2])
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present one request at a negedge and hold it through its acceptance edge.
    task automatic send(input int i, input logic wen, input logic [63:0] addr,
                        input logic [1:0] size, input logic uns, input logic [63:0] wdata);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_before_send", {63'b0, req_ready[i]}, 64'd1);
        req_wen[i]      = wen;
        req_addr[i]     = addr;
        req_size[i]     = size;
        req_unsigned[i] = uns;
        req_wdata[i]    = wdata;
        req_valid[i]    = 1'b1;
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    // Wait for the response, check latency and payload, optionally stall, then take it.
    task automatic get_resp(input int i, input string tag, input int exp_lat, input int stall,
                            input logic [63:0] exp_rdata, input logic exp_err);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid[i] && n < 40);
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_rdata"}, resp_rdata[i], exp_rdata);
        check({tag, "_err"}, {63'b0, resp_err[i]}, {63'b0, exp_err});
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, {63'b0, resp_valid[i]}, 64'd1);
            check({tag, "_stall_rdata"}, resp_rdata[i], exp_rdata);
            check({tag, "_stall_req_ready"}, {63'b0, req_ready[i]}, 64'd0);
        end
        resp_ready[i] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[i] = 1'b0;
        check({tag, "_back_idle"}, {63'b0, req_ready[i]}, 64'd1);
    endtask

    task automatic xact(input int i, input string tag, input logic wen, input logic [63:0] addr,
                        input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                        input int lat, input logic [63:0] exp_rdata, input logic exp_err);
        send(i, wen, addr, size, uns, wdata);
        get_resp(i, tag, lat, 0, exp_rdata, exp_err);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_acc;
        int n_resp;
        int last_acc;

        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_wen[i] = 1'b0; req_addr[i] = 64'd0;
            req_size[i] = 2'd0; req_unsigned[i] = 1'b0; req_wdata[i] = 64'd0;
            resp_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_req_ready", {63'b0, req_ready[i]}, 64'd1);
            check("rst_resp_valid", {63'b0, resp_valid[i]}, 64'd0);
            check("rst_resp_rdata", resp_rdata[i], 64'd0);
            check("rst_resp_err", {63'b0, resp_err[i]}, 64'd0);
            check("rst_state", {62'b0, dbg_state[i]}, 64'd0);
        end

        // LATENCY=1: lane steering, masking, extension
        xact(0, "st_d",      1, 64'h8000_0010, 2'd3, 0, 64'h1122_3344_5566_7788, 1, 64'd0, 0);
        xact(0, "ld_d",      0, 64'h8000_0010, 2'd3, 0, 64'd0, 1, 64'h1122_3344_5566_7788, 0);
        xact(0, "st_b",      1, 64'h8000_0013, 2'd0, 0, 64'h0000_0000_0000_00AB, 1, 64'd0, 0);
        xact(0, "ld_wu",     0, 64'h8000_0010, 2'd2, 1, 64'd0, 1, 64'h0000_0000_AB66_7788, 0);
        xact(0, "ld_ws",     0, 64'h8000_0010, 2'd2, 0, 64'd0, 1, 64'hFFFF_FFFF_AB66_7788, 0);
        xact(0, "ld_bs",     0, 64'h8000_0013, 2'd0, 0, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFAB, 0);
        xact(0, "ld_bu",     0, 64'h8000_0013, 2'd0, 1, 64'd0, 1, 64'h0000_0000_0000_00AB, 0);
        xact(0, "ld_hs",     0, 64'h8000_0012, 2'd1, 0, 64'd0, 1, 64'hFFFF_FFFF_FFFF_AB66, 0);
        xact(0, "ld_hu_hi",  0, 64'h8000_0016, 2'd1, 1, 64'd0, 1, 64'h0000_0000_0000_1122, 0);
        xact(0, "ld_wu_hi",  0, 64'h8000_0014, 2'd2, 1, 64'd0, 1, 64'h0000_0000_1122_3344, 0);
        xact(0, "ld_d_us",   0, 64'h8000_0010, 2'd3, 1, 64'd0, 1, 64'h1122_3344_AB66_7788, 0);
        // errors: misaligned and out of range, none may write
        xact(0, "ld_h_mis",  0, 64'h8000_0001, 2'd1, 0, 64'd0, 1, 64'd0, 1);
        xact(0, "st_w_mis",  1, 64'h8000_0012, 2'd2, 0, 64'h0000_0000_FFFF_FFFF, 1, 64'd0, 1);
        xact(0, "ld_d_keep", 0, 64'h8000_0010, 2'd3, 0, 64'd0, 1, 64'h1122_3344_AB66_7788, 0);
        xact(0, "st_last",   1, 64'h8000_7FF8, 2'd3, 0, 64'hA5A5_A5A5_A5A5_A5A5, 1, 64'd0, 0);
        xact(0, "st_below",  1, 64'h7FFF_FFF8, 2'd2, 0, 64'h0000_0000_FFFF_FFFF, 1, 64'd0, 1);
        xact(0, "ld_last",   0, 64'h8000_7FF8, 2'd3, 0, 64'd0, 1, 64'hA5A5_A5A5_A5A5_A5A5, 0);
        xact(0, "ld_past",   0, 64'h8000_8000, 2'd3, 0, 64'd0, 1, 64'd0, 1);
        xact(0, "st_h_hi",   1, 64'h8000_0016, 2'd1, 0, 64'h0000_0000_0000_BEEF, 1, 64'd0, 0);
        xact(0, "ld_d_mask", 0, 64'h8000_0010, 2'd3, 0, 64'd0, 1, 64'hBEEF_3344_AB66_7788, 0);

        // LATENCY=4 with a stalled consumer
        xact(1, "l4_st_d",   1, 64'h8000_0020, 2'd3, 0, 64'hDEAD_BEEF_CAFE_F00D, 4, 64'd0, 0);
        send(1, 0, 64'h8000_0020, 2'd3, 0, 64'd0);
        get_resp(1, "l4_ld_stall", 4, 3, 64'hDEAD_BEEF_CAFE_F00D, 0);
        xact(1, "l4_ld_ws",  0, 64'h8000_0024, 2'd2, 0, 64'd0, 4, 64'hFFFF_FFFF_DEAD_BEEF, 0);

        // LATENCY=3: reset while the store's response is pending
        send(2, 1, 64'h8000_0040, 2'd3, 0, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        check("mid_rst_in_wait", {62'b0, dbg_state[2]}, 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_resp_valid", {63'b0, resp_valid[2]}, 64'd0);
        check("mid_rst_req_ready", {63'b0, req_ready[2]}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_no_resp", {63'b0, resp_valid[2]}, 64'd0);
        check("post_rst_req_ready", {63'b0, req_ready[2]}, 64'd1);
        xact(2, "l3_ld_after_rst", 0, 64'h8000_0040, 2'd3, 0, 64'd0, 3, 64'h0123_4567_89AB_CDEF, 0);

        // Back-to-back loads with req_valid and resp_ready held high
        n_acc = 0;
        n_resp = 0;
        last_acc = -1;
        @(negedge clk);
        req_wen[2] = 1'b0; req_addr[2] = 64'h8000_0040; req_size[2] = 2'd3;
        req_unsigned[2] = 1'b0; req_valid[2] = 1'b1; resp_ready[2] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clk);
            if (req_valid[2] && req_ready[2]) begin
                n_acc++;
                if (last_acc >= 0) check("b2b_spacing", 64'(cyc - last_acc), 64'd4);
                last_acc = cyc;
                exp_q.push_back(64'h0123_4567_89AB_CDEF);
            end
            if (resp_valid[2] && resp_ready[2]) begin
                n_resp++;
                if (exp_q.size() == 0) check("b2b_extra_resp", 64'd1, 64'd0);
                else check("b2b_rdata", resp_rdata[2], exp_q.pop_front());
            end
        end
        @(negedge clk);
        req_valid[2] = 1'b0;
        resp_ready[2] = 1'b0;
        check("b2b_accepts", 64'(n_acc), 64'd6);
        check("b2b_responses", 64'(n_resp), 64'd6);
        check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
